// File: rtl/r_type_exec.sv
// ============================================================================
//  Module   : r_type_exec
//  Purpose  : RV32I R-type execute/writeback stage with 32x32 register file.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module r_type_exec #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            Radd_en,
   input  logic            Rsub_en,
   input  logic            Rand_en,
   input  logic            Ror_en,
   input  logic            Rsll_en,
   input  logic            Rslt_en,
   input  logic            Rsltu_en,
   input  logic            Rxor_en,
   input  logic            Rsrl_en,
   input  logic            Rsra_en,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic            rd_en,
   input  logic            wr_en,
   input  logic            ld_en,
   input  logic [4:0]      ld_addr,
   input  logic [XLEN-1:0] ld_data,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic [XLEN-1:0] result,
   output logic [4:0]      result_rd,
   output logic            result_valid,
   output logic            illegal,
   output logic [31:0]     retired_count
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] result_q;
   logic [4:0]      result_rd_q;
   logic            result_valid_q;
   logic            wr_en_q;
   logic            illegal_q;
   logic [31:0]     retired_q;
   logic [31:0]     retired_d;

   logic [9:0]      en_vec;
   logic            one_hot;
   logic            wb_fire;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_res;

   assign en_vec  = {Rsra_en, Rsrl_en, Rxor_en, Rsltu_en, Rslt_en,
                     Rsll_en, Ror_en, Rand_en, Rsub_en, Radd_en};
   assign one_hot = (en_vec != 10'd0) && ((en_vec & (en_vec - 10'd1)) == 10'd0);

   assign wb_fire   = result_valid_q && wr_en_q && (result_rd_q != 5'd0);
   assign retired_d = retired_q + 32'd1;

   // The WB-stage result bypasses the array; preload data never does.
   always_comb begin
      op_a = '0;
      if (rd_en && rs1 != 5'd0) begin
         if (wb_fire && result_rd_q == rs1) op_a = result_q;
         else                               op_a = regs_q[rs1];
      end
   end

   always_comb begin
      op_b = '0;
      if (rd_en && rs2 != 5'd0) begin
         if (wb_fire && result_rd_q == rs2) op_b = result_q;
         else                               op_b = regs_q[rs2];
      end
   end

   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      if (Radd_en)       alu_res = op_a + op_b;
      else if (Rsub_en)  alu_res = op_a - op_b;
      else if (Rand_en)  alu_res = op_a & op_b;
      else if (Ror_en)   alu_res = op_a | op_b;
      else if (Rxor_en)  alu_res = op_a ^ op_b;
      else if (Rsll_en)  alu_res = op_a << shamt;
      else if (Rsrl_en)  alu_res = op_a >> shamt;
      else if (Rsra_en)  alu_res = $unsigned($signed(op_a) >>> shamt);
      else if (Rslt_en)  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      else if (Rsltu_en) alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
         result_q       <= '0;
         result_rd_q    <= '0;
         result_valid_q <= 1'b0;
         wr_en_q        <= 1'b0;
         illegal_q      <= 1'b0;
         retired_q      <= '0;
      end else begin
         // Writeback is assigned last so it wins a same-address preload.
         if (ld_en && ld_addr != 5'd0) regs_q[ld_addr] <= ld_data;
         if (wb_fire)                  regs_q[result_rd_q] <= result_q;

         if (in_valid) begin
            if (one_hot) begin
               result_q       <= alu_res;
               result_rd_q    <= rd;
               wr_en_q        <= wr_en;
               result_valid_q <= 1'b1;
               illegal_q      <= 1'b0;
               retired_q      <= retired_d;
            end else begin
               result_valid_q <= 1'b0;
               illegal_q      <= 1'b1;
            end
         end else begin
            result_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
         end
      end
   end

   assign dbg_data      = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
   assign result        = result_q;
   assign result_rd     = result_rd_q;
   assign result_valid  = result_valid_q;
   assign illegal       = illegal_q;
   assign retired_count = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_r_type_exec.sv
// ============================================================================
//  Module   : tb_r_type_exec
//  Purpose  : Scoreboard bench for r_type_exec with directed instruction steps.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_r_type_exec;

   localparam int OP_ADD    = 0;
   localparam int OP_SUB    = 1;
   localparam int OP_AND    = 2;
   localparam int OP_OR     = 3;
   localparam int OP_SLL    = 4;
   localparam int OP_SLT    = 5;
   localparam int OP_SLTU   = 6;
   localparam int OP_XOR    = 7;
   localparam int OP_SRL    = 8;
   localparam int OP_SRA    = 9;
   localparam int OP_ADDSUB = 10;
   localparam int OP_NONE   = 11;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [9:0]  en = '0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic        rd_en = 1'b0, wr_en = 1'b0, ld_en = 1'b0;
   logic [4:0]  ld_addr = '0, dbg_addr = '0;
   logic [31:0] ld_data = '0;
   logic [31:0] dbg_data, result, retired_count;
   logic [4:0]  result_rd;
   logic        result_valid, illegal;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        vld;
      logic        ill;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_reg [32];
   logic [31:0] last_result;
   logic [31:0] model_count;
   logic [4:0]  pend_rd;
   int          n_checks = 0;
   int          n_errors = 0;

   r_type_exec dut (
      .clock(clock), .reset(reset), .in_valid(in_valid),
      .Radd_en(en[0]), .Rsub_en(en[1]), .Rand_en(en[2]), .Ror_en(en[3]),
      .Rsll_en(en[4]), .Rslt_en(en[5]), .Rsltu_en(en[6]), .Rxor_en(en[7]),
      .Rsrl_en(en[8]), .Rsra_en(en[9]),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rd_en(rd_en), .wr_en(wr_en),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .result(result), .result_rd(result_rd), .result_valid(result_valid),
      .illegal(illegal), .retired_count(retired_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      logic [31:0] r;
      sh = int'(b[4:0]);
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a + ~b + 32'd1;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  begin
            r = a >> sh;
            if (a[31]) for (int k = 0; k < sh; k++) r[31-k] = 1'b1;
         end
         OP_SLT:  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         OP_SLTU: r = {31'd0, (a < b)};
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check_pop(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
         return;
      end
      e = sb.pop_front();
      check({tag, "_valid"},   {31'd0, result_valid}, {31'd0, e.vld});
      check({tag, "_illegal"}, {31'd0, illegal},      {31'd0, e.ill});
      check({tag, "_result"},  result,                e.res);
      if (e.vld) check({tag, "_rd"}, {27'd0, result_rd}, {27'd0, e.rd});
      check({tag, "_count"},   retired_count,         model_count);
   endtask

   task automatic issue(input string tag, input int op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic we, input logic re);
      exp_t        e;
      logic [31:0] a, b;
      in_valid = 1'b1;
      rd = d; rs1 = s1; rs2 = s2; wr_en = we; rd_en = re;
      if (op <= OP_SRA)          en = 10'd1 << op;
      else if (op == OP_ADDSUB)  en = 10'b0000000011;
      else                       en = 10'd0;
      a = re ? model_reg[s1] : 32'd0;
      b = re ? model_reg[s2] : 32'd0;
      e.rd = d;
      if (op <= OP_SRA) begin
         e.res = model_alu(op, a, b);
         e.vld = 1'b1;
         e.ill = 1'b0;
         last_result = e.res;
         model_count = model_count + 32'd1;
         if (we && d != 5'd0) model_reg[d] = e.res;
         pend_rd = (we && d != 5'd0) ? d : 5'd0;
      end else begin
         e.res = last_result;
         e.vld = 1'b0;
         e.ill = 1'b1;
         pend_rd = 5'd0;
      end
      sb.push_back(e);
      tick();
      check_pop(tag);
   endtask

   task automatic idle(input string tag);
      exp_t e;
      in_valid = 1'b0;
      en = '0;
      e.res = last_result;
      e.rd = '0;
      e.vld = 1'b0;
      e.ill = 1'b0;
      sb.push_back(e);
      pend_rd = 5'd0;
      tick();
      check_pop(tag);
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      in_valid = 1'b0;
      en = '0;
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      // A writeback to the same index in this cycle takes priority.
      if (a != 5'd0 && a != pend_rd) model_reg[a] = d;
      pend_rd = 5'd0;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic dbg(input string tag, input logic [4:0] a);
      dbg_addr = a;
      #1;
      check(tag, dbg_data, model_reg[a]);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_reg[i] = '0;
      last_result = '0;
      model_count = '0;
      pend_rd = '0;
      sb.delete();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_result", result, 32'd0);
      check("rst_valid", {31'd0, result_valid}, 32'd0);
      check("rst_illegal", {31'd0, illegal}, 32'd0);
      check("rst_count", retired_count, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      tick();

      preload(5'd7, 32'd5);
      preload(5'd4, 32'd3);
      issue("add", OP_ADD, 5'd9, 5'd7, 5'd4, 1'b1, 1'b1);
      issue("sub_fwd", OP_SUB, 5'd11, 5'd9, 5'd4, 1'b1, 1'b1);
      idle("idle1");
      dbg("dbg_x9", 5'd9);
      dbg("dbg_x11", 5'd11);

      preload(5'd5, 32'h8000_0000);
      preload(5'd6, 32'd4);
      issue("sra", OP_SRA, 5'd13, 5'd5, 5'd6, 1'b1, 1'b1);
      issue("srl", OP_SRL, 5'd14, 5'd5, 5'd6, 1'b1, 1'b1);
      issue("slt", OP_SLT, 5'd16, 5'd5, 5'd6, 1'b1, 1'b1);
      issue("sltu", OP_SLTU, 5'd17, 5'd5, 5'd6, 1'b1, 1'b1);
      issue("sll", OP_SLL, 5'd18, 5'd6, 5'd6, 1'b1, 1'b1);
      issue("xor", OP_XOR, 5'd19, 5'd7, 5'd4, 1'b1, 1'b1);
      issue("or", OP_OR, 5'd23, 5'd13, 5'd7, 1'b1, 1'b1);
      issue("and", OP_AND, 5'd24, 5'd23, 5'd14, 1'b1, 1'b1);
      issue("rden0", OP_OR, 5'd25, 5'd7, 5'd4, 1'b1, 1'b0);
      idle("idle2");
      dbg("dbg_x13", 5'd13);
      dbg("dbg_x18", 5'd18);
      dbg("dbg_x24", 5'd24);

      issue("add_x0", OP_ADD, 5'd0, 5'd7, 5'd4, 1'b1, 1'b1);
      issue("add_nowr", OP_ADD, 5'd20, 5'd7, 5'd4, 1'b0, 1'b1);
      issue("fwd_nowr", OP_ADD, 5'd26, 5'd20, 5'd7, 1'b1, 1'b1);
      idle("idle3");
      dbg("dbg_x0", 5'd0);
      dbg("dbg_x20", 5'd20);

      issue("ill_two", OP_ADDSUB, 5'd21, 5'd7, 5'd4, 1'b1, 1'b1);
      issue("ill_none", OP_NONE, 5'd21, 5'd7, 5'd4, 1'b1, 1'b1);
      idle("idle4");
      dbg("dbg_x21", 5'd21);

      issue("add_x15", OP_ADD, 5'd15, 5'd7, 5'd4, 1'b1, 1'b1);
      preload(5'd15, 32'h0000_DEAD);
      preload(5'd22, 32'h1234_5678);
      dbg("dbg_x15_wbwins", 5'd15);
      dbg("dbg_x22", 5'd22);

      issue("pre_rst", OP_ADD, 5'd12, 5'd7, 5'd4, 1'b1, 1'b1);
      in_valid = 1'b0;
      en = '0;
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("arst_result", result, 32'd0);
      check("arst_valid", {31'd0, result_valid}, 32'd0);
      check("arst_count", retired_count, 32'd0);
      @(posedge clock);
      #1;
      dbg("arst_x12", 5'd12);
      dbg("arst_x7", 5'd7);
      @(negedge clock);
      reset = 1'b1;
      tick();
      issue("post_rst", OP_ADD, 5'd3, 5'd7, 5'd4, 1'b1, 1'b1);
      idle("idle5");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/r_type_exec.md
Name: r_type_exec

Overview:
- Execute/writeback stage directly downstream of the RV32I R-type decoder.
- Consumes the decoder's one-hot operation enables, register indices and read/write enables.
- Reads operands from an internal 32x32 register file, computes the ALU result, registers it, and commits it to the register file one cycle later.
- Includes WB-to-EX forwarding, a preload port, a debug read port, an illegal-enable flag and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width (fixed at 32; shift amounts use rs2[4:0]).
- NREGS, 32, register count; index width 5.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoder outputs are valid this cycle (issue).
- Radd_en, Rsub_en, Rand_en, Ror_en, Rsll_en, Rslt_en, Rsltu_en, Rxor_en, Rsrl_en, Rsra_en  in  1 each  one-hot operation select from the decoder.
- rs1, rs2, rd  in  5 each  source and destination indices.
- rd_en  in  1  operand read enable; 0 forces both operands to 0.
- wr_en  in  1  writeback enable.
- ld_en  in  1  preload write strobe.
- ld_addr  in  5  preload address.
- ld_data  in  32  preload data.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  committed register value at dbg_addr, combinational.
- result  out  32  registered ALU result (WB stage).
- result_rd  out  5  WB-stage destination.
- result_valid  out  1  WB stage holds a legal issued instruction.
- illegal  out  1  registered: last issue had zero or more than one enable set.
- retired_count  out  32  count of legal issued instructions.

Behaviour:
- Reset (reset=0, asynchronous): all 32 registers, result, result_rd, result_valid, illegal and retired_count = 0; any in-flight writeback is discarded.
- Operand read, EX stage (combinational in the issue cycle):
  - opA = reg[rs1]; opB = reg[rs2].
  - x0 always reads 0.
  - Forwarding: if the WB stage has result_valid, wr_en_q=1, result_rd!=0 and result_rd equals the source index, use result instead of the array value.
  - rd_en=0 forces opA = opB = 0.
- ALU, all modulo 2^32:
  - add: opA+opB. sub: opA-opB.
  - and, or, xor: bitwise.
  - sll: opA << opB[4:0]. srl: logical right shift. sra: arithmetic right shift.
  - slt: signed compare, result is 1 or 0. sltu: unsigned compare, result is 1 or 0.
- Issue cycle edge (in_valid=1):
  - Exactly one enable set: result<=ALU, result_rd<=rd, wr_en_q<=wr_en, result_valid<=1, illegal<=0, retired_count+=1 (wraps 0xFFFFFFFF to 0).
  - Zero or more than one enable set: result_valid<=0, illegal<=1, result unchanged, no count.
- in_valid=0: result_valid<=0, illegal<=0, result holds its value.
- Writeback edge (the cycle after issue): if result_valid, wr_en_q=1 and result_rd!=0, then reg[result_rd]<=result. Writes to x0 are dropped, but result is still produced.
- Latency: result visible 1 cycle after issue; the array is updated at the end of the following cycle; back-to-back dependent instructions need no stall.
- Preload: when ld_en=1 and ld_addr!=0, reg[ld_addr]<=ld_data at the edge.
  - Writeback to the same address in the same cycle wins.
  - Preload data is not forwarded.
- dbg_data shows the array only (not forwarded). A same-cycle write shows the old value until the edge.
- Throughput: one instruction per cycle; no backpressure.

Test Plan:
- Reset, preload x7=5, x4=3; issue add rd=9, rs1=7, rs2=4 -> next cycle result=8, result_rd=9, result_valid=1; after one more cycle dbg_data(9)=8; retired_count=1.
- Back-to-back: add x9=x7+x4, then sub x11=x9-x4 on the next cycle -> forwarded result 5; dbg x11=5.
- Preload x5=0x80000000, x6=4; sra -> 0xF8000000; srl -> 0x08000000; slt x5,x6 -> 1; sltu x5,x6 -> 0; sll x6 by x6 -> 0x40.
- rd=0 with wr_en=1: result=8 but dbg x0 stays 0. wr_en=0: result computed, array unchanged.
- Issue with Radd_en and Rsub_en both set, then with no enable set -> illegal=1, result_valid=0, count unchanged, no write.
- Assert reset mid-stream with a writeback pending -> write suppressed; all outputs and registers 0; retired_count 0.
